// File: rtl/proc_pkg.sv
// Shared processor constants and types: reset PC, NOP encoding, cache line geometry, fetch FSM states.
package proc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned LINE_W           = 128;
  localparam int unsigned LINE_OFS_W       = 4;

  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:LINE_OFS_W], 4'b0000};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: valid bits with reset, tag/data arrays without.
module icache_array
  import proc_pkg::*;
#(
  parameter int unsigned LINES = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned TAG_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [LINE_W-1:0] rdata
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] lines [LINES];

  // Reset takes priority so a write coinciding with reset never leaves a valid line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx]  <= wtag;
      lines[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = lines[ridx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, direct-mapped I-cache lookup, line refill FSM and F/D register.
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned LINES    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dhit,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       pc_d,
  output logic              ihit
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - LINE_OFS_W - IDX_W;

  fetch_state_t      state;
  logic [31:0]       pc;
  logic [31:0]       miss_addr;
  logic              rvalid;
  logic [TAG_W-1:0]  rtag;
  logic [LINE_W-1:0] rdata;
  logic              hit_c;
  logic              we_c;
  logic [31:0]       word_c;
  logic [31:0]       redir_pc_c;

  assign redir_pc_c = redirect_pc & ~32'h0000_0003;
  assign hit_c      = rvalid && (rtag == pc[31 -: TAG_W]);
  assign we_c       = (state == REFILL) && mem_ack && reset;
  assign mem_addr   = miss_addr;

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (we_c),
    .widx   (miss_addr[LINE_OFS_W +: IDX_W]),
    .wtag   (miss_addr[31 -: TAG_W]),
    .wdata  (mem_rdata),
    .ridx   (pc[LINE_OFS_W +: IDX_W]),
    .rvalid (rvalid),
    .rtag   (rtag),
    .rdata  (rdata)
  );

  // Word select within the looked-up line.
  always_comb begin
    word_c = rdata[31:0];
    case (pc[3:2])
      2'd1:    word_c = rdata[63:32];
      2'd2:    word_c = rdata[95:64];
      2'd3:    word_c = rdata[127:96];
      default: word_c = rdata[31:0];
    endcase
  end

  // Refill runs regardless of dhit; PC and F/D only move when decode advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      miss_addr <= '0;
      mem_req   <= 1'b0;
      instr     <= NOP_INSTR;
      pc_d      <= '0;
      ihit      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dhit) begin
            if (redirect) begin
              pc   <= redir_pc_c;
              ihit <= 1'b0;
            end else if (hit_c) begin
              pc    <= pc + 32'd4;
              instr <= word_c;
              pc_d  <= pc;
              ihit  <= 1'b1;
            end else begin
              miss_addr <= line_base(pc);
              mem_req   <= 1'b1;
              state     <= REFILL;
              ihit      <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RUN;
          end
          if (dhit) begin
            ihit <= 1'b0;
            if (redirect) begin
              pc <= redir_pc_c;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetches are queued at redirect/resume, popped on each advancing ihit.
module tb_fetch_unit;
  import proc_pkg::*;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         dhit;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic [31:0]  instr;
  logic [31:0]  pc_d;
  logic         ihit;

  int tests = 0;
  int fails = 0;
  int req_cycles = 0;
  int wait_cnt = 0;
  bit auto_mem = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] ack_log[$];

  fetch_unit #(.RESET_PC(32'h0000_1000), .LINES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .dhit        (dhit),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .pc_d        (pc_d),
    .ihit        (ihit)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] base);
    return {mem_word(base + 32'd12), mem_word(base + 32'd8), mem_word(base + 32'd4), mem_word(base)};
  endfunction

  // One clock: scoreboard check on advancing fetches, then the memory responder.
  task automatic cycle();
    bit adv;
    logic [31:0] e;
    adv = dhit && reset;
    @(posedge clk);
    #1;
    if (mem_req) req_cycles++;
    if (adv && ihit) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc_d=%h instr=%h, expected no fetch", pc_d, instr);
      end else begin
        e = exp_q.pop_front();
        if (pc_d !== e || instr !== mem_word(e)) begin
          fails++;
          $display("FAIL sb_fetch: got pc_d=%h instr=%h, expected pc_d=%h instr=%h",
                   pc_d, instr, e, mem_word(e));
        end
      end
    end
    if (auto_mem) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == LAT - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_line(mem_addr);
          ack_log.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  task automatic drain(input int bound, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d fetches outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Redirect to target, expect count sequential fetches, then park with dhit=0.
  task automatic run_to(input logic [31:0] target, input int count, input string name);
    logic [31:0] a;
    dhit        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = target;
    cycle();
    redirect = 1'b0;
    a = target & ~32'h3;
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
    drain(80, name);
    dhit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; dhit = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    cycle();
    cycle();
    tests++; if (ihit !== 1'b0) begin fails++; $display("FAIL reset_ihit: got %b expected 0", ihit); end
    tests++; if (instr !== 32'h0000_0013) begin fails++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    tests++; if (pc_d !== 32'h0) begin fails++; $display("FAIL reset_pc_d: got %h expected 00000000", pc_d); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_cold_start();
    int n;
    reset = 1'b1;
    dhit  = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_1000 + 32'(4 * i));
    n = 0;
    do begin cycle(); n++; end while (ihit !== 1'b1 && n < 20);
    tests++;
    if (ihit !== 1'b1) begin fails++; $display("FAIL cold_first_hit: got ihit=%b expected 1", ihit); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (ihit !== 1'b1) begin fails++; $display("FAIL cold_consecutive: got ihit=%b expected 1 (step %0d)", ihit, i); end
    end
    tests++;
    if (ack_log.size() < 1 || ack_log[0] !== 32'h0000_1000) begin
      fails++; $display("FAIL cold_refill_addr: got %0d refills, expected first at 00001000", ack_log.size());
    end
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin cycle(); n++; end
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1010) begin
      fails++; $display("FAIL cold_next_miss: got mem_req=%b mem_addr=%h expected 1/00001010", mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect_refill();
    int n0;
    n0 = ack_log.size();
    run_to(32'h0000_2002, 1, "redir_refill");
    tests++;
    if (ack_log.size() != n0 + 2 || ack_log[n0] !== 32'h0000_1010 || ack_log[n0+1] !== 32'h0000_2000) begin
      fails++; $display("FAIL redir_refill_order: got %0d refills, expected 00001010 then 00002000", ack_log.size() - n0);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      redirect    = 1'b1;
      redirect_pc = 32'h0000_3000;
      cycle();
      tests++;
      if (ihit !== 1'b1 || pc_d !== 32'h0000_2000 || instr !== mem_word(32'h0000_2000)) begin
        fails++; $display("FAIL stall_hold: got ihit=%b pc_d=%h instr=%h expected 1/00002000/%h",
                          ihit, pc_d, instr, mem_word(32'h0000_2000));
      end
    end
    redirect = 1'b0;
    exp_q.push_back(32'h0000_2004);
    exp_q.push_back(32'h0000_2008);
    dhit = 1'b1;
    drain(20, "stall_resume");
    dhit = 1'b0;
  endtask

  task automatic test_conflict();
    int n0;
    n0 = ack_log.size();
    run_to(32'h0000_1000, 1, "conflict_a");
    run_to(32'h0000_1040, 1, "conflict_b");
    run_to(32'h0000_1000, 1, "conflict_a2");
    tests++;
    if (ack_log.size() != n0 + 3 || ack_log[n0] !== 32'h0000_1000 ||
        ack_log[n0+1] !== 32'h0000_1040 || ack_log[n0+2] !== 32'h0000_1000) begin
      fails++; $display("FAIL conflict_refills: got %0d refills, expected 1000/1040/1000", ack_log.size() - n0);
    end
  endtask

  task automatic test_warm_loop();
    int r0;
    r0 = req_cycles;
    dhit        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1000;
    cycle();
    redirect = 1'b0;
    tests++;
    if (ihit !== 1'b0) begin fails++; $display("FAIL warm_bubble: got ihit=%b expected 0", ihit); end
    exp_q.push_back(32'h0000_1000);
    cycle();
    tests++;
    if (ihit !== 1'b1) begin fails++; $display("FAIL warm_hit: got ihit=%b expected 1", ihit); end
    dhit = 1'b0;
    drain(1, "warm_sb");
    tests++;
    if (req_cycles != r0) begin fails++; $display("FAIL warm_no_req: got %0d req cycles expected 0", req_cycles - r0); end
  endtask

  task automatic test_reset_during_ack();
    int n;
    run_to(32'h0000_1040, 1, "rst_prep");
    auto_mem    = 1'b0;
    mem_ack     = 1'b0;
    dhit        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1000;
    cycle();
    redirect = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin cycle(); n++; end
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000) begin
      fails++; $display("FAIL rst_pre_req: got mem_req=%b mem_addr=%h expected 1/00001000", mem_req, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = mem_line(32'h0000_1000);
    reset     = 1'b0;
    cycle();
    mem_ack = 1'b0;
    tests++;
    if (mem_req !== 1'b0 || ihit !== 1'b0) begin
      fails++; $display("FAIL rst_abort: got mem_req=%b ihit=%b expected 0/0", mem_req, ihit);
    end
    reset    = 1'b1;
    wait_cnt = 0;
    auto_mem = 1'b1;
    exp_q.push_back(32'h0000_1000);
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin cycle(); n++; end
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000) begin
      fails++; $display("FAIL rst_refetch: got mem_req=%b mem_addr=%h expected 1/00001000", mem_req, mem_addr);
    end
    drain(20, "rst_refetch_sb");
    dhit = 1'b0;
  endtask

  task automatic test_wrap();
    run_to(32'hFFFF_FFFC, 2, "wrap");
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_redirect_refill();
    test_stall();
    test_conflict();
    test_warm_loop();
    test_reset_during_ack();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_1000, first fetch address after reset.
REQ-002 SHALL provide parameter LINES, default 4, number of direct-mapped instruction-cache lines (16 bytes each).
REQ-003 SHALL provide clk  input  1  rising-edge clock.
REQ-004 SHALL provide reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide dhit  input  1  pipeline advance enable; 0 freezes PC and F/D register.
REQ-006 SHALL provide redirect  input  1  taken branch/jump from decode.
REQ-007 SHALL provide redirect_pc  input  32  redirect target.
REQ-008 SHALL provide mem_req  output  1  line refill request.
REQ-009 SHALL provide mem_addr  output  32  line-aligned refill address.
REQ-010 SHALL provide mem_ack  input  1  one-cycle refill-data-valid strobe.
REQ-011 SHALL provide mem_rdata  input  128  refill line, word 0 in bits [31:0].
REQ-012 SHALL provide instr  output  32  F/D instruction to decode (opcode/funct source).
REQ-013 SHALL provide pc_d  output  32  PC of instr.
REQ-014 SHALL provide ihit  output  1  instr valid; 0 = bubble.

Function
REQ-015 SHALL split PC as tag = pc[31:4+log2(LINES)], index = pc[3+log2(LINES):4], word = pc[3:2].
REQ-016 SHALL have FSM states RUN and REFILL.
REQ-017 RUN, hit, dhit=1, redirect=0: next edge pc<=pc+4, instr<=cached word, pc_d<=pc, ihit<=1.
REQ-018 RUN, miss, dhit=1: next edge capture miss_addr={pc[31:4],4'b0}, enter REFILL, ihit<=0; pc unchanged.
REQ-019 REFILL: mem_req=1, mem_addr=miss_addr, both stable until mem_ack; mem_req SHALL be 0 in RUN.
REQ-020 mem_ack in REFILL: write line, tag, valid bit at miss_addr index; return to RUN; refilled word hits next cycle (miss penalty = memory latency + 2 cycles).
REQ-021 mem_ack in RUN SHALL be ignored.
REQ-022 Refill SHALL progress independently of dhit.
REQ-023 dhit=0: pc, instr, pc_d, ihit SHALL hold; redirect SHALL be ignored (decode holds it).
REQ-024 redirect=1 with dhit=1 SHALL take priority over hit/miss: pc<={redirect_pc[31:2],2'b00}, ihit<=0 (flush), in either state.
REQ-025 Redirect during REFILL SHALL not abort the refill; old line completes, lookup resumes at new pc.
REQ-026 In REFILL with dhit=1 and no redirect, ihit<=0 each cycle.
REQ-027 PC increment SHALL wrap modulo 2^32.

Reset
REQ-028 When reset=0 at a clock edge: pc<=RESET_PC, state<=RUN, all valid bits<=0, ihit<=0, instr<=32'h0000_0013, pc_d<=0, mem_req<=0.
REQ-029 Reset mid-refill SHALL abandon the refill; the pending line SHALL NOT be written even if mem_ack coincides with reset.
REQ-030 Tags/data arrays SHALL not require reset.

Structure
REQ-031 Shared package proc_pkg SHALL hold RESET_PC default, NOP encoding, line width, state enum.
REQ-032 Tag/valid/data storage SHALL be sub-module icache_array (one write port, one combinational read port).

Verification
REQ-033 Cold start: reset released, mem acks after 3 cycles with line 0x1000 -> mem_addr=0x1000, then ihit=1 with pc_d 0x1000,0x1004,0x1008,0x100C on consecutive cycles, then miss at 0x1010.
REQ-034 Warm loop: redirect_pc=0x1000 after line cached -> one bubble, pc_d=0x1000 next valid, no mem_req.
REQ-035 dhit=0 for 4 cycles mid-stream -> instr/pc_d/ihit frozen, resume at next sequential pc without loss or duplication.
REQ-036 Redirect to 0x2002 during REFILL of 0x1010 -> refill completes at 0x1010, next mem_addr=0x2000, first valid pc_d=0x2000.
REQ-037 reset=0 asserted in cycle mem_ack=1 -> mem_req=0, line not valid, refetch of same line requested after reset.
REQ-038 Conflict: 0x1000 then 0x1040 (same index, LINES=4) -> second fetch misses, evicts; return to 0x1000 misses again.
